// File: rtl/conv_output_reader_pkg.sv
// Shared CNN parameters for the conv output reader slice.
//   CNN_DATA_WIDTH : default width of one feature-map element
//   state_e        : reader FSM states
//   clog2_min1()   : ceil(log2(n)) with a floor of 1, so index ports never collapse to zero width
package conv_output_reader_pkg;

  localparam int CNN_DATA_WIDTH = 32;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_e;

  function automatic int clog2_min1(input int n);
    int r;
    r = 1;
    // Stop at bit 30 so (1 << i) never goes negative.
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/conv_output_reader_elem_counter.sv
// conv_elem_counter: walks the (map, row, col) index space, column fastest.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   clr_i           return all indices to (0,0,0); wins over adv_i
//   adv_i           step to the next element
//   map_o/row_o/col_o  current indices
//   elem_nxt_o      flat index (m*OH*OW + r*OW + c) the counter will hold after this edge
//   last_in_map_o   current element is (r=OH-1, c=OW-1)
//   last_o          current element is also in the final map
module conv_elem_counter
  import conv_output_reader_pkg::*;
#(
  parameter int K  = 6,
  parameter int OH = 28,
  parameter int OW = 28,
  localparam int MW = clog2_min1(K),
  localparam int RW = clog2_min1(OH),
  localparam int CW = clog2_min1(OW),
  localparam int EW = clog2_min1(K * OH * OW)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_i,
  input  logic          adv_i,
  output logic [MW-1:0] map_o,
  output logic [RW-1:0] row_o,
  output logic [CW-1:0] col_o,
  output logic [EW-1:0] elem_nxt_o,
  output logic          last_in_map_o,
  output logic          last_o
);

  logic [MW-1:0] map_q, map_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [EW-1:0] elem_q, elem_d;
  logic          col_end, row_end, map_end;

  assign col_end = (col_q == CW'(OW - 1));
  assign row_end = (row_q == RW'(OH - 1));
  assign map_end = (map_q == MW'(K - 1));

  always_comb begin
    map_d  = map_q;
    row_d  = row_q;
    col_d  = col_q;
    elem_d = elem_q;
    if (clr_i) begin
      map_d  = '0;
      row_d  = '0;
      col_d  = '0;
      elem_d = '0;
    end else if (adv_i) begin
      // The flat index runs alongside so the top can select the element without a multiply.
      elem_d = elem_q + EW'(1);
      if (col_end) begin
        col_d = '0;
        if (row_end) begin
          row_d = '0;
          map_d = map_q + MW'(1);
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      map_q  <= '0;
      row_q  <= '0;
      col_q  <= '0;
      elem_q <= '0;
    end else begin
      map_q  <= map_d;
      row_q  <= row_d;
      col_q  <= col_d;
      elem_q <= elem_d;
    end
  end

  assign map_o         = map_q;
  assign row_o         = row_q;
  assign col_o         = col_q;
  assign elem_nxt_o    = elem_d;
  assign last_in_map_o = col_end & row_end;
  assign last_o        = col_end & row_end & map_end;

endmodule

// File: rtl/conv_output_reader.sv
// conv_output_reader: streams a flat conv-layer result bus one element per
// valid/ready transfer, ordered column fastest, then row, then map.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   start             begin a stream (only honoured in IDLE, ignored with abort)
//   abort             cancel the current stream; beats a same-cycle transfer
//   feature_maps      K*OH*OW elements, element e at [e*DATA_WIDTH +: DATA_WIDTH];
//                     must stay stable for the whole stream
//   out_ready         downstream accepts the presented element
//   out_valid         element and indices are valid
//   out_data          registered element value
//   out_map/row/col   indices of the presented element
//   out_last_in_map   presented element closes its map
//   out_last          presented element closes the stream
//   busy              stream in progress
//   done              one-cycle pulse after the final transfer
module conv_output_reader
  import conv_output_reader_pkg::*;
#(
  parameter int DATA_WIDTH = CNN_DATA_WIDTH,
  parameter int K          = 6,
  parameter int OH         = 28,
  parameter int OW         = 28,
  localparam int MW = clog2_min1(K),
  localparam int RW = clog2_min1(OH),
  localparam int CW = clog2_min1(OW),
  localparam int EW = clog2_min1(K * OH * OW),
  localparam int NB = K * OH * OW * DATA_WIDTH,
  localparam int BW = clog2_min1(NB)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [0:NB-1]         feature_maps,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [MW-1:0]         out_map,
  output logic [RW-1:0]         out_row,
  output logic [CW-1:0]         out_col,
  output logic                  out_last_in_map,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done
);

  state_e                state_q, state_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic                  in_stream, xfer;
  logic                  start_ok, abort_ok, fin;
  logic                  cnt_clr, cnt_adv;
  logic                  cnt_lim, cnt_last;
  logic [EW-1:0]         elem_nxt;
  logic [BW-1:0]         bit_base;
  logic [DATA_WIDTH-1:0] elem_sel;

  conv_elem_counter #(
    .K  (K),
    .OH (OH),
    .OW (OW)
  ) u_cnt (
    .clk           (clk),
    .reset         (reset),
    .clr_i         (cnt_clr),
    .adv_i         (cnt_adv),
    .map_o         (out_map),
    .row_o         (out_row),
    .col_o         (out_col),
    .elem_nxt_o    (elem_nxt),
    .last_in_map_o (cnt_lim),
    .last_o        (cnt_last)
  );

  // out_valid is the state bit itself, so it never sees out_ready combinationally.
  assign in_stream = (state_q == ST_STREAM);
  assign xfer      = in_stream & out_ready;
  assign start_ok  = (state_q == ST_IDLE) & start & ~abort;
  assign abort_ok  = in_stream & abort;
  assign fin       = xfer & ~abort & cnt_last;
  assign cnt_clr   = start_ok | abort_ok | fin;
  assign cnt_adv   = xfer & ~abort & ~cnt_last;

  // Select the element the counter is about to point at, so out_data lines
  // up with the indices on the same edge.
  assign bit_base = BW'(elem_nxt) * BW'(DATA_WIDTH);
  assign elem_sel = feature_maps[bit_base +: DATA_WIDTH];

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) state_d = ST_STREAM;
      end
      ST_STREAM: begin
        if (abort_ok || fin) state_d = ST_IDLE;
        done_d = fin;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    data_d = data_q;
    if (start_ok || cnt_adv) begin
      data_d = elem_sel;
    end else if (abort_ok || fin) begin
      data_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      data_q  <= data_d;
    end
  end

  assign out_valid       = in_stream;
  assign busy            = in_stream;
  assign done            = done_q;
  assign out_data        = data_q;
  assign out_last_in_map = in_stream & cnt_lim;
  assign out_last        = in_stream & cnt_last;

endmodule

// File: tb/tb_conv_output_reader.sv
module tb_conv_output_reader;
  import conv_output_reader_pkg::*;

  localparam int DW  = 32;
  localparam int SK  = 2;
  localparam int SOH = 3;
  localparam int SOW = 3;
  localparam int SN  = SK * SOH * SOW;
  localparam int BK  = 6;
  localparam int BOH = 28;
  localparam int BOW = 28;
  localparam int BN  = BK * BOH * BOW;
  localparam int SMW = clog2_min1(SK);
  localparam int SRW = clog2_min1(SOH);
  localparam int SCW = clog2_min1(SOW);
  localparam int BMW = clog2_min1(BK);
  localparam int BRW = clog2_min1(BOH);
  localparam int BCW = clog2_min1(BOW);

  typedef struct {
    logic [DW-1:0] data;
    int            m;
    int            r;
    int            c;
    logic          lim;
    logic          last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset;

  // Small instance: K=2, 3x3 maps
  logic             s_start, s_abort, s_ready;
  logic [0:SN*DW-1] s_fm;
  logic             s_valid, s_lim, s_last, s_busy, s_done;
  logic [DW-1:0]    s_data;
  logic [SMW-1:0]   s_map;
  logic [SRW-1:0]   s_row;
  logic [SCW-1:0]   s_col;

  // Default-size instance
  logic             b_start, b_abort, b_ready;
  logic [0:BN*DW-1] b_fm;
  logic             b_valid, b_lim, b_last, b_busy, b_done;
  logic [DW-1:0]    b_data;
  logic [BMW-1:0]   b_map;
  logic [BRW-1:0]   b_row;
  logic [BCW-1:0]   b_col;

  conv_output_reader #(.DATA_WIDTH(DW), .K(SK), .OH(SOH), .OW(SOW)) u_small (
    .clk(clk), .reset(reset), .start(s_start), .abort(s_abort), .feature_maps(s_fm),
    .out_ready(s_ready), .out_valid(s_valid), .out_data(s_data), .out_map(s_map),
    .out_row(s_row), .out_col(s_col), .out_last_in_map(s_lim), .out_last(s_last),
    .busy(s_busy), .done(s_done)
  );

  conv_output_reader #(.DATA_WIDTH(DW), .K(BK), .OH(BOH), .OW(BOW)) u_big (
    .clk(clk), .reset(reset), .start(b_start), .abort(b_abort), .feature_maps(b_fm),
    .out_ready(b_ready), .out_valid(b_valid), .out_data(b_data), .out_map(b_map),
    .out_row(b_row), .out_col(b_col), .out_last_in_map(b_lim), .out_last(b_last),
    .busy(b_busy), .done(b_done)
  );

  // Reference model state: element values, expected-transfer queues, stream flags.
  logic [DW-1:0] s_vals [SN];
  logic [DW-1:0] b_vals [BN];
  exp_t s_q[$];
  exp_t b_q[$];
  bit   s_exp_busy, s_exp_done, s_hold;
  bit   b_exp_busy, b_exp_done, b_hold;
  int   s_xfers, b_xfers, b_lim_seen;
  logic [63:0] s_snap, b_snap;
  int   n_checks;
  int   n_errors;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, mid-cycle, for both instances.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      chk("s_rst_out", {s_valid, s_data, s_map, s_row, s_col, s_lim, s_last, s_busy, s_done}, 64'd0);
      chk("b_rst_out", {b_valid, b_data, b_map, b_row, b_col, b_lim, b_last, b_busy, b_done}, 64'd0);
      s_q.delete(); b_q.delete();
      s_exp_busy = 0; s_exp_done = 0; s_hold = 0; s_xfers = 0;
      b_exp_busy = 0; b_exp_done = 0; b_hold = 0; b_xfers = 0; b_lim_seen = 0;
    end else begin
      // ---- small instance
      chk("s_valid", s_valid, s_exp_busy);
      chk("s_busy", s_busy, s_exp_busy);
      chk("s_done", s_done, s_exp_done);
      if (s_hold) chk("s_stall_hold", {s_data, s_map, s_row, s_col, s_lim, s_last}, s_snap);
      s_exp_done = 0;
      if (s_exp_busy && s_abort) begin
        s_exp_busy = 0; s_q.delete(); s_xfers = 0;
      end else if (s_exp_busy && s_valid && s_ready) begin
        chk("s_q_nonempty", s_q.size() > 0, 1);
        if (s_q.size() > 0) begin
          e = s_q.pop_front();
          s_xfers++;
          chk("s_data", s_data, e.data);
          chk("s_idx", {s_map, s_row, s_col}, {SMW'(e.m), SRW'(e.r), SCW'(e.c)});
          chk("s_flags", {s_lim, s_last}, {e.lim, e.last});
          if (e.last) begin
            chk("s_count", s_xfers, SN);
            s_exp_busy = 0; s_exp_done = 1; s_xfers = 0;
          end
        end
      end else if (!s_exp_busy && s_start && !s_abort) begin
        s_exp_busy = 1;
      end
      s_hold = s_exp_busy && s_valid && !s_ready && !s_abort;
      s_snap = 64'({s_data, s_map, s_row, s_col, s_lim, s_last});

      // ---- default-size instance
      chk("b_valid", b_valid, b_exp_busy);
      chk("b_busy", b_busy, b_exp_busy);
      chk("b_done", b_done, b_exp_done);
      if (b_hold) chk("b_stall_hold", {b_data, b_map, b_row, b_col, b_lim, b_last}, b_snap);
      b_exp_done = 0;
      if (b_exp_busy && b_abort) begin
        b_exp_busy = 0; b_q.delete(); b_xfers = 0;
      end else if (b_exp_busy && b_valid && b_ready) begin
        chk("b_q_nonempty", b_q.size() > 0, 1);
        if (b_q.size() > 0) begin
          e = b_q.pop_front();
          b_xfers++;
          if (b_lim) b_lim_seen++;
          chk("b_data", b_data, e.data);
          chk("b_idx", {b_map, b_row, b_col}, {BMW'(e.m), BRW'(e.r), BCW'(e.c)});
          chk("b_flags", {b_lim, b_last}, {e.lim, e.last});
          if (e.last) begin
            chk("b_count", b_xfers, BN);
            chk("b_lim_count", b_lim_seen, BK);
            b_exp_busy = 0; b_exp_done = 1; b_xfers = 0; b_lim_seen = 0;
          end
        end
      end else if (!b_exp_busy && b_start && !b_abort) begin
        b_exp_busy = 1;
      end
      b_hold = b_exp_busy && b_valid && !b_ready && !b_abort;
      b_snap = 64'({b_data, b_map, b_row, b_col, b_lim, b_last});
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_small(input bit rnd);
    for (int e = 0; e < SN; e++) begin
      s_vals[e] = rnd ? DW'($urandom) : DW'(e);
      s_fm[e*DW +: DW] = s_vals[e];
    end
  endtask

  task automatic wait_idle(input string nm, input int bound, input bit big);
    int n;
    n = 0;
    while ((big ? b_exp_busy : s_exp_busy) && n < bound) begin
      if (big) b_ready = ($urandom_range(0, 3) != 0);
      step(1);
      n++;
    end
    if (big ? b_exp_busy : s_exp_busy) begin
      $display("FAIL %s: stream still active after %0d cycles", nm, bound);
      $fatal(1);
    end
  endtask

  // Expected stream: every element in map, row, column order.
  task automatic start_small();
    exp_t e;
    wait_idle("s_idle_before_start", 500, 0);
    for (int m = 0; m < SK; m++)
      for (int r = 0; r < SOH; r++)
        for (int c = 0; c < SOW; c++) begin
          e.data = s_vals[(m * SOH + r) * SOW + c];
          e.m = m; e.r = r; e.c = c;
          e.lim  = (r == SOH - 1) && (c == SOW - 1);
          e.last = e.lim && (m == SK - 1);
          s_q.push_back(e);
        end
    s_start = 1;
    step(1);
    s_start = 0;
  endtask

  task automatic run_small_pattern(input int bound);
    int n;
    n = 0;
    while (s_exp_busy && n < bound) begin
      s_ready = (n % 4 == 0) || (n % 4 == 3);
      step(1);
      n++;
    end
    if (s_exp_busy) begin
      $display("FAIL s_pattern_run: stream still active after %0d cycles", bound);
      $fatal(1);
    end
  endtask

  initial begin
    exp_t e;
    reset = 1; s_start = 0; s_abort = 0; s_ready = 1; s_fm = '0;
    b_start = 0; b_abort = 0; b_ready = 0; b_fm = '0;
    #2 reset = 0;
    step(3);
    reset = 1;
    step(2);

    // Straight stream, values 0..17, always ready
    set_small(0);
    start_small();
    wait_idle("s_plain", 100, 0);
    step(3);

    // Ready pattern 1,0,0,1 with random values
    set_small(1);
    start_small();
    run_small_pattern(200);
    s_ready = 1;
    step(3);

    // start and abort together in IDLE
    s_start = 1; s_abort = 1;
    step(1);
    s_start = 0; s_abort = 0;
    step(3);

    // Abort while element 7 is presented
    set_small(0);
    start_small();
    step(7);
    s_abort = 1;
    step(1);
    s_abort = 0;
    step(3);
    start_small();
    wait_idle("s_after_abort", 100, 0);
    step(2);

    // Reset while element 4 is presented
    start_small();
    step(4);
    reset = 0;
    step(2);
    reset = 1;
    step(5);
    start_small();
    wait_idle("s_after_reset", 100, 0);
    step(2);

    // start pulses at elements 2 and 10 mid-stream
    set_small(1);
    start_small();
    step(2);
    s_start = 1;
    step(1);
    s_start = 0;
    step(7);
    s_start = 1;
    step(1);
    s_start = 0;
    wait_idle("s_start_ignored", 100, 0);
    step(3);

    // Default-size stream with random backpressure
    for (int i = 0; i < BN; i++) begin
      b_vals[i] = DW'($urandom);
      b_fm[i*DW +: DW] = b_vals[i];
    end
    for (int m = 0; m < BK; m++)
      for (int r = 0; r < BOH; r++)
        for (int c = 0; c < BOW; c++) begin
          e.data = b_vals[(m * BOH + r) * BOW + c];
          e.m = m; e.r = r; e.c = c;
          e.lim  = (r == BOH - 1) && (c == BOW - 1);
          e.last = e.lim && (m == BK - 1);
          b_q.push_back(e);
        end
    b_start = 1;
    step(1);
    b_start = 0;
    wait_idle("b_random", 40000, 1);
    step(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/conv_output_reader.md
CONV_OUTPUT_READER -- requirements
Module: conv_output_reader

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of one feature-map element.
REQ-002 Parameter K, default 6, number of feature maps on the input bus.
REQ-003 Parameter OH, default 28, output map height; parameter OW, default 28, output map width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 start  input  1  request to stream the feature-map bus; sampled only in IDLE.
REQ-007 abort  input  1  synchronous cancel of an in-progress stream.
REQ-008 feature_maps  input  K*OH*OW*DATA_WIDTH, declared [0:N-1]  conv layer result bus; element e = m*OH*OW + r*OW + c occupies bits [e*DATA_WIDTH +: DATA_WIDTH].
REQ-009 out_ready  input  1  downstream accepts current element.
REQ-010 out_valid  output  1  out_data and index outputs hold a valid element.
REQ-011 out_data  output  DATA_WIDTH  current element value.
REQ-012 out_map / out_row / out_col  output  clog2(K) / clog2(OH) / clog2(OW) (min 1)  indices of current element.
REQ-013 out_last_in_map  output  1  current element is (r=OH-1, c=OW-1).
REQ-014 out_last  output  1  current element is the final element of the final map.
REQ-015 busy  output  1  high in STREAM state.
REQ-016 done  output  1  one-cycle pulse after the final element transfers.

Function
REQ-017 The block SHALL implement states IDLE and STREAM.
REQ-018 IDLE -> STREAM when start=1 and abort=0; out_valid SHALL be 1 on the following cycle with element (0,0,0).
REQ-019 A transfer SHALL occur on any rising edge with out_valid=1 and out_ready=1.
REQ-020 After a non-final transfer, the next element SHALL be presented the following cycle (no bubble), order c fastest, then r, then m.
REQ-021 Index wrap: c=OW-1 -> c=0, r+1; r=OH-1 and c=OW-1 -> r=0, c=0, m+1.
REQ-022 With out_valid=1 and out_ready=0, out_data and all index/flag outputs SHALL remain stable.
REQ-023 out_valid SHALL NOT depend combinationally on out_ready; out_data SHALL be registered.
REQ-024 Transfer of the element with out_last=1 SHALL return to IDLE, clear out_valid, and pulse done for exactly one cycle.
REQ-025 start while in STREAM SHALL be ignored.
REQ-026 abort=1 in STREAM SHALL return to IDLE next cycle with out_valid=0, counters zeroed, no done pulse; abort takes priority over a same-cycle transfer.
REQ-027 start=1 and abort=1 together in IDLE SHALL leave the block in IDLE.
REQ-028 feature_maps SHALL be held stable by upstream from start acceptance until done or abort; the block does not capture the whole bus.
REQ-029 Total transfers per stream SHALL equal exactly K*OH*OW.

Reset
REQ-030 reset=0 SHALL immediately force IDLE, out_valid=0, busy=0, done=0, out_data=0, all indices and flags 0.
REQ-031 Reset asserted mid-stream SHALL discard the stream; after release, no output until a new start.

Structure
REQ-032 DATA_WIDTH default and a clog2 constant function SHALL live in the shared CNN parameters include file.
REQ-033 The map/row/col counter with wrap and last flags SHALL be a sub-module conv_elem_counter; element selection and handshake stay in the top.

Verification
REQ-034 K=2, OH=OW=3, out_ready=1, maps hold values 0..17: stream 18 elements in order 0..17 on consecutive cycles; out_last on 17; done one cycle after.
REQ-035 Same config, out_ready toggled 1,0,0,1 repeatedly: each value appears once, held unchanged through stall cycles.
REQ-036 abort asserted with element 7 presented and out_ready=1: element 7 not counted, out_valid=0 next cycle, no done; new start restarts at element 0.
REQ-037 reset pulled low while element 4 presented: all outputs 0 asynchronously; after release, out_valid stays 0 until start.
REQ-038 start pulsed at elements 2 and 10 during stream: ignored; exactly 18 transfers and one done.
REQ-039 Defaults K=6, OH=OW=28, random out_ready: 4704 transfers, out_last_in_map at every 784th, indices match scoreboard.
